// File: rtl/seg_scan_hex.sv
// seg_scan_hex: multiplexed 7-seg hex scanner, frame-latched digit data.
// Leading-zero blanking is built only when SEG_SCAN_LZB_EN is defined.
module seg_scan_hex #(
  parameter int DIGITS         = 6,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                en,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blank_lz,
  output logic [DIGITS-1:0]   seg_sel,
  output logic [7:0]          seg_led,
  output logic                frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] CNT_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_V  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic [DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                active;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_lz;

  logic                tick;
  logic                wrap;
  logic                start;
  logic                cap;

  logic [4*DIGITS-1:0] src_data;
  logic [DIGITS-1:0]   src_dp;
  logic                src_lz;
  logic [DIGITS-1:0]   lz_mask;

  logic [3:0]          nib;
  logic                cur_dp;
  logic                cur_lz;
  logic                on;
  logic [DIGITS-1:0]   sel_nxt;
  logic [7:0]          seg_nxt;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0:    f = 7'h3F;
      4'h1:    f = 7'h06;
      4'h2:    f = 7'h5B;
      4'h3:    f = 7'h4F;
      4'h4:    f = 7'h66;
      4'h5:    f = 7'h6D;
      4'h6:    f = 7'h7D;
      4'h7:    f = 7'h07;
      4'h8:    f = 7'h7F;
      4'h9:    f = 7'h6F;
      4'hA:    f = 7'h77;
      4'hB:    f = 7'h7C;
      4'hC:    f = 7'h39;
      4'hD:    f = 7'h5E;
      4'hE:    f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Slot/frame boundaries and the capture strobe
  always_comb begin
    tick  = (cnt == CNT_LAST);
    wrap  = tick && (idx == IDX_LAST);
    start = en && !active;
    cap   = start || (en && wrap);
  end

  // Prescaler and digit index; disable parks both at zero
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Frame shadows reload only at frame start, never mid-frame
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
      sh_lz   <= 1'b0;
    end else if (cap) begin
      sh_data <= data;
      sh_dp   <= dp;
      sh_lz   <= blank_lz;
    end
  end

  // On the enable-start edge the shadows are stale, so show live inputs
  always_comb begin
    src_data = start ? data : sh_data;
    src_dp   = start ? dp : sh_dp;
    src_lz   = start ? blank_lz : sh_lz;
  end

`ifdef SEG_SCAN_LZB_EN
  logic zrun;

  // Flag digits inside the zero run that starts at the top digit
  always_comb begin
    zrun    = src_lz;
    lz_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zrun       = zrun && (src_data[4*k +: 4] == 4'h0);
      lz_mask[k] = zrun;
    end
  end
`else
  logic lz_unused;
  assign lz_unused = src_lz;
  assign lz_mask   = '0;
`endif

  // Pick the current digit and build active-high select/segments
  always_comb begin
    nib     = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    sel_nxt = '0;
    seg_nxt = 8'h00;
    on      = en && (cnt >= BLANK_V);
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib        = src_data[4*k +: 4];
        cur_dp     = src_dp[k];
        cur_lz     = lz_mask[k];
        sel_nxt[k] = on;
      end
    end
    if (on) begin
      seg_nxt = {cur_dp, cur_lz ? 7'h00 : font(nib)};
    end
  end

  // Output registers; polarity applied here only
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seg_sel    <= SEL_OFF;
      seg_led    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      seg_sel    <= sel_nxt ^ SEL_OFF;
      seg_led    <= seg_nxt ^ SEG_OFF;
      frame_done <= cap;
    end
  end

endmodule

// File: tb/tb_seg_scan_hex.sv
// tb_seg_scan_hex: directed bench for seg_scan_hex, 4 digits, div 4.
// Cycle model derives outputs from the enabled-cycle count.
module tb_seg_scan_hex;

  localparam int D = 4;
  localparam int C = 4;
  localparam int B = 1;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b0;
  logic         en = 1'b1;
  logic [15:0]  data = 16'h12AF;
  logic [3:0]   dp = 4'h0;
  logic         blank_lz = 1'b0;
  logic [3:0]   seg_sel;
  logic [7:0]   seg_led;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_hex #(
    .DIGITS(D),
    .CLK_DIV(C),
    .BLANK_CYC(B),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .en(en),
    .data(data),
    .dp(dp),
    .blank_lz(blank_lz),
    .seg_sel(seg_sel),
    .seg_led(seg_led),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [6:0] font_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: outputs follow from k = enabled cycles since scan start
  logic       running = 1'b0;
  int         k = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;
  logic [3:0]  exp_sel = 4'hF;
  logic [7:0]  exp_led = 8'hFF;
  logic        exp_fd = 1'b0;

  always @(posedge sys_clk or posedge sys_rst) begin : model
    int kk, slot, dig;
    logic [15:0] sd;
    logic [3:0] sdp;
    logic slz, sup;
    logic [7:0] led;
    if (sys_rst) begin
      running <= 1'b0;
      k       <= 0;
      m_data  <= '0;
      m_dp    <= '0;
      m_lz    <= 1'b0;
      exp_sel <= 4'hF;
      exp_led <= 8'hFF;
      exp_fd  <= 1'b0;
    end else if (!en) begin
      running <= 1'b0;
      exp_sel <= 4'hF;
      exp_led <= 8'hFF;
      exp_fd  <= 1'b0;
    end else begin
      if (!running) begin
        kk = 0; sd = data; sdp = dp; slz = blank_lz;
      end else begin
        kk = k + 1; sd = m_data; sdp = m_dp; slz = m_lz;
      end
      slot = kk % C;
      dig  = (kk / C) % D;
      sup  = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      if (slz && dig != 0) begin
        sup = 1'b1;
        for (int j = dig; j < D; j++)
          if (sd[4*j +: 4] != 4'h0) sup = 1'b0;
      end
`endif
      led = {sdp[dig], sup ? 7'h00 : font_of(sd[4*dig +: 4])};
      if (slot >= B) begin
        exp_sel <= ~(4'b0001 << dig);
        exp_led <= ~led;
      end else begin
        exp_sel <= 4'hF;
        exp_led <= 8'hFF;
      end
      exp_fd <= !running || (kk % (D*C) == D*C - 1);
      if (kk % (D*C) == D*C - 1) begin
        m_data <= data; m_dp <= dp; m_lz <= blank_lz;
      end else if (!running) begin
        m_data <= sd; m_dp <= sdp; m_lz <= slz;
      end
      k       <= kk;
      running <= 1'b1;
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge sys_clk) begin
    chk("model_sel", 32'(seg_sel), 32'(exp_sel));
    chk("model_led", 32'(seg_led), 32'(exp_led));
    chk("model_fd", 32'(frame_done), 32'(exp_fd));
  end

  task automatic wait_sel(input string name, input logic [3:0] s,
                          input logic [7:0] led);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge sys_clk);
      if (seg_sel == s) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: select %h not seen, expected within 40", name, s);
    end else begin
      chk(name, 32'(seg_led), 32'(led));
    end
  endtask

  task automatic wait_fd(input string name);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge sys_clk);
      if (frame_done) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_done timeout, expected within 40", name);
    end
  endtask

  initial begin
    int n;
    bit hit;
    logic [7:0] lz_top;
`ifdef SEG_SCAN_LZB_EN
    lz_top = 8'hFF;
`else
    lz_top = 8'hC0;
`endif
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", 32'(seg_sel), 32'h0000_000F);
    chk("rst_led", 32'(seg_led), 32'h0000_00FF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("start_fd", 32'(frame_done), 32'h1);

    wait_sel("dec_d0", 4'hE, 8'h8E);
    wait_sel("dec_d1", 4'hD, 8'h88);
    wait_sel("dec_d2", 4'hB, 8'hA4);
    wait_sel("dec_d3", 4'h7, 8'hF9);

    wait_fd("period_a");
    n = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge sys_clk);
      n++;
      if (frame_done) hit = 1;
    end
    chk("fd_period", 32'(n), 32'd16);

    dp = 4'b0010;
    wait_fd("dp_load");
    @(negedge sys_clk);
    chk("blank_sel", 32'(seg_sel), 32'h0000_000F);
    chk("blank_led", 32'(seg_led), 32'h0000_00FF);
    wait_sel("dp_d1", 4'hD, 8'h08);

    data = 16'h1111;
    dp = 4'h0;
    wait_fd("tear_load");
    repeat (6) @(negedge sys_clk);
    data = 16'h2222;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge sys_clk);
      if (frame_done) hit = 1;
      else if (seg_sel != 4'hF)
        chk("tear_old", 32'(seg_led), 32'h0000_00F9);
    end
    if (!hit) chk("tear_fd", 32'(frame_done), 32'h1);
    wait_sel("tear_new", 4'hE, 8'hA4);

    data = 16'h0030;
    blank_lz = 1'b1;
    wait_fd("lz_load");
    wait_sel("lz_d3", 4'h7, lz_top);
    wait_sel("lz_d2", 4'hB, lz_top);
    wait_sel("lz_d1", 4'hD, 8'hB0);
    wait_sel("lz_d0", 4'hE, 8'hC0);

    wait_sel("en_d2", 4'hB, lz_top);
    en = 1'b0;
    @(negedge sys_clk);
    chk("dis_sel", 32'(seg_sel), 32'h0000_000F);
    chk("dis_led", 32'(seg_led), 32'h0000_00FF);
    chk("dis_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge sys_clk);
    data = 16'h5555;
    blank_lz = 1'b0;
    en = 1'b1;
    @(negedge sys_clk);
    chk("en_fd", 32'(frame_done), 32'h1);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge sys_clk);
      if (seg_sel != 4'hF) hit = 1;
    end
    chk("en_first_sel", 32'(seg_sel), 32'h0000_000E);
    chk("en_first_led", 32'(seg_led), 32'h0000_0092);

    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(seg_sel), 32'h0000_000F);
    chk("mid_rst_led", 32'(seg_led), 32'h0000_00FF);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst2_fd", 32'(frame_done), 32'h1);
    wait_sel("rst2_d0", 4'hE, 8'h92);

    repeat (20) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_hex.md
# seg_scan_hex

Parametrised multiplexed seven-segment hex display driver; the successor to the fixed three-byte, six-digit display used beside `uart_mcu` on the board top level. It scans `DIGITS` common-electrode digits from one packed nibble bus and has per-digit decimal points. It also adds a programmable inter-digit blanking (anti-ghosting) interval, tear-free frame-latched data, and optional leading-zero suppression. It sits at board top level between debug/MCU outputs and the `seg_sel`/`seg_led` pins.

## Interface
- `DIGITS`, 6: number of digits scanned, 1..16.
- `CLK_DIV`, 50000: `sys_clk` cycles per digit slot, at least 2 (50000 gives 1 kHz digit rate at 50 MHz).
- `BLANK_CYC`, 500: cycles at slot start with all digits deselected, less than `CLK_DIV`.
- `SEL_ACTIVE_LOW`, 1: 1 means `seg_sel` is active-low.
- `SEG_ACTIVE_LOW`, 1: 1 means `seg_led` is active-low.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `en` in 1: scan enable.
- `data` in 4*DIGITS: nibble k (`data[4k+3:4k]`) drives digit k; digit 0 is rightmost.
- `dp` in DIGITS: decimal point k lights on digit k.
- `blank_lz` in 1: request leading-zero blanking (see Configuration).
- `seg_sel` out DIGITS: digit select; bit k selects digit k.
- `seg_led` out 8: segment bus `{dp,g,f,e,d,c,b,a}`.
- `frame_done` out 1: one-cycle pulse when the shadow registers reload.

## Operation
- Internal state: a prescaler counting 0..CLK_DIV-1, a digit index counting 0..DIGITS-1, and shadow registers for `data`, `dp` and `blank_lz`.
- Tick: the prescaler equals CLK_DIV-1. On a tick the prescaler goes to 0 and the index advances. The index wraps from DIGITS-1 to 0.
- Shadow capture happens on the same edge as the index wraps to 0. It also happens on the first enabled cycle after `en` rises or after reset is released with `en`=1. Inputs are never sampled mid-frame, so a frame never shows mixed data.
- Font, active-high internal, bit0 = a:
  - 0 through 7: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8 through F: 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Bit7 carries the shadow `dp[k]`.
- Select for digit k is asserted only while the index equals k and the prescaler is at least BLANK_CYC. During the blank interval all selects are inactive and `seg_led` is off.
- Each polarity parameter inverts its bus at the output register only.
- `en`=0:
  - The prescaler and index are synchronously cleared to 0.
  - All selects are inactive, all segments are off, and `frame_done` is 0.
- Reset mid-frame: all state returns to reset values immediately. Scanning restarts at digit 0 with a fresh capture.

## Timing
- Reset values:
  - `seg_sel` all inactive (all 1s when SEL_ACTIVE_LOW).
  - `seg_led` off (FF when SEG_ACTIVE_LOW).
  - `frame_done`=0.
  - Prescaler 0, index 0, shadows 0.
- `seg_sel`, `seg_led` and `frame_done` are registered. They reflect the prescaler/index state with 1 cycle of latency.
- Each slot lasts exactly CLK_DIV cycles, and a frame lasts DIGITS×CLK_DIV cycles. The selected (non-blanked) time per slot is CLK_DIV−BLANK_CYC cycles.
- `frame_done` is high for the single cycle after each shadow capture, including the enable-start capture.
- DIGITS=1: the index stays at 0 and a capture occurs every CLK_DIV cycles.
- BLANK_CYC=0: there is no blank interval.

## Configuration
- Macro `SEG_SCAN_LZB_EN`.
- Defined: when the shadow `blank_lz`=1, the segments a–g are suppressed for each digit from DIGITS-1 downward whose nibble is 0, up to the first nonzero nibble.
  - Digit 0 is never suppressed.
  - The decimal point of a suppressed digit still follows `dp`.
  - The select still pulses normally.
- Undefined: the `blank_lz` port exists but is ignored, and every digit shows its nibble.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=4, BLANK_CYC=1, both polarities active-low, unless noted.
- Reset: hold `sys_rst`=1 with any inputs. Expect `seg_sel`=F, `seg_led`=FF, `frame_done`=0. Deasserting reset with `en`=1 gives a `frame_done` pulse 1 cycle later.
- Decode: `data`=12AF, `dp`=0. Expect:
  - digit0 `seg_sel`=E, `seg_led`=8E;
  - digit1 D/88;
  - digit2 B/A4;
  - digit3 7/F9;
  - `frame_done` period of 16 cycles.
- Blanking and dp: `dp`=0010. Expect the first cycle of each slot to have `seg_sel`=F and `seg_led`=FF, and digit1 to show `seg_led`=08.
- Tear-free: change `data` from 1111 to 2222 mid-frame. Expect all digits to show F9 until the next `frame_done`, then A4.
- Leading-zero suppression: `data`=0030, `blank_lz`=1, macro defined. Expect digits 3 and 2 to show FF, digit1 B0 and digit0 C0. With the macro undefined, digits 3 and 2 show C0.
- Enable: drop `en` mid-slot of digit2. Expect the outputs inactive on the next cycle. Raise `en` with new data 5555. Expect `frame_done`, then digit0 to be the first selected and show 92.
